// File: rtl/alu_pkg.sv
// Shared ALU opcode, MIPS op/funct constants and decode bundle types.
// Used by the issue stage, its decoder, and the ALU.
package alu_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int ALU_OP_W   = 5;

  localparam logic [4:0] ALU_AND   = 5'h00;
  localparam logic [4:0] ALU_OR    = 5'h01;
  localparam logic [4:0] ALU_ADD   = 5'h02;
  localparam logic [4:0] ALU_XOR   = 5'h03;
  localparam logic [4:0] ALU_SLL   = 5'h04;
  localparam logic [4:0] ALU_SRL   = 5'h05;
  localparam logic [4:0] ALU_SUB   = 5'h06;
  localparam logic [4:0] ALU_SLT   = 5'h07;
  localparam logic [4:0] ALU_SRA   = 5'h08;
  localparam logic [4:0] ALU_SRLV  = 5'h09;
  localparam logic [4:0] ALU_SRAV  = 5'h0A;
  localparam logic [4:0] ALU_SLLV  = 5'h0B;
  localparam logic [4:0] ALU_NOR   = 5'h0C;
  localparam logic [4:0] ALU_ADDU  = 5'h0D;
  localparam logic [4:0] ALU_SUBU  = 5'h0E;
  localparam logic [4:0] ALU_SLTU  = 5'h0F;
  localparam logic [4:0] ALU_ADDI  = 5'h10;
  localparam logic [4:0] ALU_ADDIU = 5'h11;
  localparam logic [4:0] ALU_ANDI  = 5'h12;
  localparam logic [4:0] ALU_ORI   = 5'h13;
  localparam logic [4:0] ALU_XORI  = 5'h14;
  localparam logic [4:0] ALU_SLTI  = 5'h15;
  localparam logic [4:0] ALU_SLTIU = 5'h16;
  localparam logic [4:0] ALU_LUI   = 5'h17;
  localparam logic [4:0] ALU_PASS  = 5'h1F;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic { B_RT  = 1'b0, B_IMM  = 1'b1 } imm_sel_e;
  typedef enum logic { X_ZERO = 1'b0, X_SIGN = 1'b1 } ext_sel_e;
  typedef enum logic { WB_RD = 1'b0, WB_RT  = 1'b1 } wb_sel_e;

  typedef struct packed {
    logic [4:0] opcode;
    imm_sel_e   imm_sel;
    ext_sel_e   ext_sel;
    wb_sel_e    wb_sel;
    logic       wb_en;
    logic       illegal;
  } dec_t;

  function automatic logic [WORD_WIDTH-1:0] ext_imm(
    input logic [15:0] imm,
    input ext_sel_e    sel
  );
    logic fill;
    fill = (sel == X_SIGN) & imm[15];
    return {{(WORD_WIDTH-16){fill}}, imm};
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Pure combinational MIPS op/funct decode into ALU control fields.
// Unlisted encodings fall back to ALU_PASS with no write-back.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec = '{opcode:  ALU_PASS,
            imm_sel: B_RT,
            ext_sel: X_ZERO,
            wb_sel:  WB_RD,
            wb_en:   1'b0,
            illegal: 1'b1};
    case (op)
      OP_RTYPE: begin
        dec.wb_en   = 1'b1;
        dec.illegal = 1'b0;
        case (funct)
          FN_AND:  dec.opcode = ALU_AND;
          FN_OR:   dec.opcode = ALU_OR;
          FN_ADD:  dec.opcode = ALU_ADD;
          FN_XOR:  dec.opcode = ALU_XOR;
          FN_SLL:  dec.opcode = ALU_SLL;
          FN_SRL:  dec.opcode = ALU_SRL;
          FN_SUB:  dec.opcode = ALU_SUB;
          FN_SLT:  dec.opcode = ALU_SLT;
          FN_SRA:  dec.opcode = ALU_SRA;
          FN_SRLV: dec.opcode = ALU_SRLV;
          FN_SRAV: dec.opcode = ALU_SRAV;
          FN_SLLV: dec.opcode = ALU_SLLV;
          FN_NOR:  dec.opcode = ALU_NOR;
          FN_ADDU: dec.opcode = ALU_ADDU;
          FN_SUBU: dec.opcode = ALU_SUBU;
          FN_SLTU: dec.opcode = ALU_SLTU;
          default: begin
            dec.wb_en   = 1'b0;
            dec.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        dec.imm_sel = B_IMM;
        dec.wb_sel  = WB_RT;
        dec.wb_en   = 1'b1;
        dec.illegal = 1'b0;
        case (op)
          OP_ADDI:  dec.opcode = ALU_ADDI;
          OP_ADDIU: dec.opcode = ALU_ADDIU;
          OP_SLTI:  dec.opcode = ALU_SLTI;
          OP_SLTIU: dec.opcode = ALU_SLTIU;
          OP_ANDI:  dec.opcode = ALU_ANDI;
          OP_ORI:   dec.opcode = ALU_ORI;
          OP_XORI:  dec.opcode = ALU_XORI;
          default:  dec.opcode = ALU_LUI;
        endcase
        if (op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU})
          dec.ext_sel = X_SIGN;
      end
      OP_LW, OP_SW: begin
        dec.opcode  = ALU_ADD;
        dec.imm_sel = B_IMM;
        dec.ext_sel = X_SIGN;
        dec.wb_sel  = WB_RT;
        dec.wb_en   = (op == OP_LW);
        dec.illegal = 1'b0;
      end
      OP_BEQ, OP_BNE: begin
        dec.opcode  = ALU_SUB;
        dec.illegal = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX register: decodes instr + rs/rt into ALU controls behind a valid/ready slot.
// Define ILLEGAL_TRAP_EN to register the illegal flag for unlisted encodings.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int ALU_OP_W   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic [WORD_WIDTH-1:0] rs_data,
  input  logic [WORD_WIDTH-1:0] rt_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ALU_OP_W-1:0]   alu_opcode,
  output logic [4:0]            alu_sa,
  output logic [WORD_WIDTH-1:0] alu_a,
  output logic [WORD_WIDTH-1:0] alu_b,
  output logic [4:0]            wb_reg,
  output logic                  wb_en,
  output logic                  illegal
);

  dec_t dec;

  alu_op_decode u_dec (
    .op    (instr[31:26]),
    .funct (instr[5:0]),
    .dec   (dec)
  );

  logic                  accept;
  logic                  valid_d, valid_q;
  logic [ALU_OP_W-1:0]   opcode_d, opcode_q;
  logic [4:0]            sa_d, sa_q;
  logic [WORD_WIDTH-1:0] a_d, a_q;
  logic [WORD_WIDTH-1:0] b_d, b_q;
  logic [4:0]            wb_reg_d, wb_reg_q;
  logic                  wb_en_d, wb_en_q;
  logic [WORD_WIDTH-1:0] imm_ext;

  assign in_ready = !valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    imm_ext = {{(WORD_WIDTH-16){1'b0}}, instr[15:0]};
    if (dec.ext_sel == X_SIGN)
      imm_ext = {{(WORD_WIDTH-16){instr[15]}}, instr[15:0]};
  end

  always_comb begin
    valid_d  = valid_q;
    opcode_d = opcode_q;
    sa_d     = sa_q;
    a_d      = a_q;
    b_d      = b_q;
    wb_reg_d = wb_reg_q;
    wb_en_d  = wb_en_q;
    // Flush wins over a same-cycle accept; data may still load harmlessly.
    if (flush)
      valid_d = 1'b0;
    else if (accept)
      valid_d = 1'b1;
    else if (out_ready)
      valid_d = 1'b0;
    if (accept) begin
      opcode_d = ALU_OP_W'(dec.opcode);
      sa_d     = instr[10:6];
      a_d      = rs_data;
      b_d      = (dec.imm_sel == B_IMM) ? imm_ext : rt_data;
      wb_reg_d = (dec.wb_sel == WB_RT) ? instr[20:16] : instr[15:11];
      wb_en_d  = dec.wb_en;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      opcode_q <= '0;
      sa_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      wb_reg_q <= '0;
      wb_en_q  <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      opcode_q <= opcode_d;
      sa_q     <= sa_d;
      a_q      <= a_d;
      b_q      <= b_d;
      wb_reg_q <= wb_reg_d;
      wb_en_q  <= wb_en_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_d, illegal_q;

  always_comb begin
    illegal_d = valid_d & (accept ? dec.illegal : illegal_q);
  end

  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`else
  logic unused_illegal;
  assign unused_illegal = dec.illegal;
  assign illegal        = 1'b0;
`endif

  assign out_valid  = valid_q;
  assign alu_opcode = opcode_q;
  assign alu_sa     = sa_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign wb_reg     = wb_reg_q;
  assign wb_en      = wb_en_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: vector table, stall/flush sequences,
// and a randomized stream against a queue-based reference model.
module tb_alu_issue_stage;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, rs_data, rt_data, alu_a, alu_b;
  logic [4:0]  alu_opcode, alu_sa, wb_reg;
  logic        wb_en, illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_opcode(alu_opcode), .alu_sa(alu_sa),
    .alu_a(alu_a), .alu_b(alu_b),
    .wb_reg(wb_reg), .wb_en(wb_en), .illegal(illegal)
  );

  typedef struct {
    logic [4:0]  opcode;
    logic [4:0]  sa;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wb_reg;
    logic        wb_en;
    logic        unl;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  opcode;
    logic [4:0]  sa;
    logic [31:0] b;
    logic [4:0]  wb_reg;
    logic        wb_en;
    logic        unl;
  } vec_t;

  // funct / op lists in opcode order: index i maps to opcode i (R) or 0x10+i (I)
  localparam logic [5:0] R_FN [16] = '{6'h24, 6'h25, 6'h20, 6'h26,
                                       6'h00, 6'h02, 6'h22, 6'h2A,
                                       6'h03, 6'h06, 6'h07, 6'h04,
                                       6'h27, 6'h21, 6'h23, 6'h2B};
  localparam logic [5:0] I_OP [8]  = '{6'h08, 6'h09, 6'h0C, 6'h0D,
                                       6'h0E, 6'h0A, 6'h0B, 6'h0F};
  localparam logic [5:0] RND_OP [14] = '{6'h08, 6'h09, 6'h0C, 6'h0D,
                                         6'h0E, 6'h0A, 6'h0B, 6'h0F,
                                         6'h23, 6'h2B, 6'h04, 6'h05,
                                         6'h3F, 6'h01};

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  function automatic exp_t ref_dec(input logic [31:0] ins,
                                   input logic [31:0] rs,
                                   input logic [31:0] rt);
    exp_t e;
    logic [5:0]  op;
    logic [31:0] sx, zx;
    op = ins[31:26];
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0, ins[15:0]};
    e = '{opcode: 5'h1F, sa: ins[10:6], a: rs, b: rt,
          wb_reg: ins[15:11], wb_en: 1'b0, unl: 1'b1};
    if (op == 6'h00)
      for (int i = 0; i < 16; i++)
        if (ins[5:0] == R_FN[i]) begin
          e.opcode = 5'(i);
          e.wb_en  = 1'b1;
          e.unl    = 1'b0;
        end
    for (int i = 0; i < 8; i++)
      if (op == I_OP[i]) begin
        e.opcode = 5'(16 + i);
        e.b      = (i < 2 || i == 5 || i == 6) ? sx : zx;
        e.wb_reg = ins[20:16];
        e.wb_en  = 1'b1;
        e.unl    = 1'b0;
      end
    if (op == 6'h23 || op == 6'h2B) begin
      e.opcode = 5'h02;
      e.b      = sx;
      e.wb_reg = ins[20:16];
      e.wb_en  = (op == 6'h23);
      e.unl    = 1'b0;
    end
    if (op == 6'h04 || op == 6'h05) begin
      e.opcode = 5'h06;
      e.unl    = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 1) == 0) begin
      w[31:26] = 6'h00;
      if ($urandom_range(0, 3) != 0) w[5:0] = R_FN[$urandom_range(0, 15)];
    end else begin
      w[31:26] = RND_OP[$urandom_range(0, 13)];
    end
    return w;
  endfunction

  task automatic check_out(input string nm, input exp_t e);
    chk({nm, "_valid"},  out_valid,  1'b1);
    chk({nm, "_opcode"}, alu_opcode, e.opcode);
    chk({nm, "_sa"},     alu_sa,     e.sa);
    chk({nm, "_a"},      alu_a,      e.a);
    if (!e.unl) chk({nm, "_b"}, alu_b, e.b);
    chk({nm, "_wb_en"},  wb_en,      e.wb_en);
    if (e.wb_en) chk({nm, "_wb_reg"}, wb_reg, e.wb_reg);
    chk({nm, "_illegal"}, illegal, e.unl & TRAP);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic ordy, input logic fl);
    in_valid  = v;
    instr     = ins;
    rs_data   = rs;
    rt_data   = rt;
    out_ready = ordy;
    flush     = fl;
  endtask

  vec_t vt[15];
  exp_t q[$];
  exp_t e;
  logic acc;

  initial begin
    vt[0]  = '{32'h00221820, 32'd5,  32'd7,  5'h02, 5'd0,  32'd7,        5'd3, 1'b1, 1'b0};
    vt[1]  = '{32'h2022FFFF, 32'd1,  32'd2,  5'h10, 5'h1F, 32'hFFFFFFFF, 5'd2, 1'b1, 1'b0};
    vt[2]  = '{32'h3422FFFF, 32'd1,  32'd2,  5'h13, 5'h1F, 32'h0000FFFF, 5'd2, 1'b1, 1'b0};
    vt[3]  = '{32'h00000000, 32'd0,  32'h1234, 5'h04, 5'd0, 32'h1234,    5'd0, 1'b1, 1'b0};
    vt[4]  = '{32'h00021883, 32'd9,  32'h80000000, 5'h08, 5'd2, 32'h80000000, 5'd3, 1'b1, 1'b0};
    vt[5]  = '{32'h8C22FFF0, 32'h100, 32'd3, 5'h02, 5'h1F, 32'hFFFFFFF0, 5'd2, 1'b1, 1'b0};
    vt[6]  = '{32'hAC22FFF0, 32'h100, 32'd3, 5'h02, 5'h1F, 32'hFFFFFFF0, 5'd2, 1'b0, 1'b0};
    vt[7]  = '{32'h10220004, 32'd4,  32'h55, 5'h06, 5'd0,  32'h55,       5'd0, 1'b0, 1'b0};
    vt[8]  = '{32'h3C028000, 32'd1,  32'd2,  5'h17, 5'd0,  32'h00008000, 5'd2, 1'b1, 1'b0};
    vt[9]  = '{32'h2C228000, 32'd1,  32'd2,  5'h16, 5'd0,  32'hFFFF8000, 5'd2, 1'b1, 1'b0};
    vt[10] = '{32'hFC000000, 32'hAB, 32'd2,  5'h1F, 5'd0,  32'd0,        5'd0, 1'b0, 1'b1};
    vt[11] = '{32'h00221801, 32'hCD, 32'd2,  5'h1F, 5'd0,  32'd0,        5'd0, 1'b0, 1'b1};
    vt[12] = '{32'h00221823, 32'd8,  32'd6,  5'h0E, 5'd0,  32'd6,        5'd3, 1'b1, 1'b0};
    vt[13] = '{32'h3822F0F0, 32'd1,  32'd2,  5'h14, 5'd3,  32'h0000F0F0, 5'd2, 1'b1, 1'b0};
    vt[14] = '{32'h14220000, 32'd1,  32'd2,  5'h06, 5'd0,  32'd2,        5'd0, 1'b0, 1'b0};

    // reset held 2 cycles while a valid instruction is offered
    reset = 1'b1;
    drive(1'b1, 32'h00221820, 32'd5, 32'd7, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_opcode", alu_opcode, 5'd0);
    chk("rst_a", alu_a, 32'd0);
    chk("rst_b", alu_b, 32'd0);
    chk("rst_wb", {wb_reg, wb_en, illegal}, 7'd0);
    chk("rst_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(1'b1, vt[i].instr, vt[i].rs, vt[i].rt, 1'b1, 1'b0);
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      e = '{opcode: vt[i].opcode, sa: vt[i].sa, a: vt[i].rs, b: vt[i].b,
            wb_reg: vt[i].wb_reg, wb_en: vt[i].wb_en, unl: vt[i].unl};
      check_out($sformatf("vec%0d", i), e);
    end

    // back-pressure: A held 3 cycles, B waits, then B loads once
    @(negedge clk);
    drive(1'b1, 32'h00221820, 32'd1, 32'd2, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h00221822, 32'd3, 32'd4, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_in_ready", in_ready, 1'b0);
      @(negedge clk);
      check_out("stall_hold", '{opcode: 5'h02, sa: 5'd0, a: 32'd1, b: 32'd2,
                                wb_reg: 5'd3, wb_en: 1'b1, unl: 1'b0});
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release_ready", in_ready, 1'b1);
    @(negedge clk);
    check_out("stall_next", '{opcode: 5'h06, sa: 5'd0, a: 32'd3, b: 32'd4,
                              wb_reg: 5'd3, wb_en: 1'b1, unl: 1'b0});
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("drain_valid", out_valid, 1'b0);

    // flush with a live output and an incoming instruction
    drive(1'b1, 32'h00221820, 32'd1, 32'd2, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_pre_valid", out_valid, 1'b1);
    drive(1'b1, 32'h00221822, 32'd3, 32'd4, 1'b0, 1'b1);
    @(negedge clk);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_illegal", illegal, 1'b0);
    drive(1'b1, 32'h3422FFFF, 32'd6, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    check_out("flush_resume", '{opcode: 5'h13, sa: 5'h1F, a: 32'd6,
                                b: 32'h0000FFFF, wb_reg: 5'd2,
                                wb_en: 1'b1, unl: 1'b0});
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

    // randomized stream against the in-order queue model
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      chk("rnd_valid", out_valid, q.size() != 0);
      if (q.size() != 0) check_out("rnd", q[0]);
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      #1;
      chk("rnd_in_ready", in_ready, (q.size() == 0) || out_ready);
      acc = in_valid && ((q.size() == 0) || out_ready);
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (flush) q.delete();
      else if (acc) q.push_back(ref_dec(instr, rs_data, rt_data));
    end
    @(negedge clk);
    chk("rnd_final_valid", out_valid, q.size() != 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
